// File: rtl/audio_player_if.sv
// SRAM bus shared between the audio player (master) and the SRAM pins / top-level mux (slave).
interface audio_player_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] sram_addr;
   wire  [DATA_W-1:0] sram_dq;
   logic              sram_ce_n;
   logic              sram_oe_n;
   logic              sram_we_n;
   logic              sram_ub_n;
   logic              sram_lb_n;

   modport master (
      output sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
      inout  sram_dq
   );

   modport slave (
      input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
      inout  sram_dq
   );
endinterface

// File: rtl/audio_player.sv
// Streams 16-bit SRAM samples to a WM8731 DAC over I2S (codec-mastered clocks),
// one word per frame, same sample on left and right.
module audio_player #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              pause,
   input  logic              stop,
   input  logic [ADDR_W-1:0] end_addr,
   audio_player_if.master    sram,
   input  logic              aud_bclk,
   input  logic              aud_daclrck,
   output logic              aud_dacdat,
   output logic              busy,
   output logic              done
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT_L, SHIFT_L, WAIT_R, SHIFT_R} state_t;

   state_t            state, state_nxt;
   logic [2:0]        bclk_sync, lr_sync;
   logic              bclk_fall, lr_fall, lr_rise;
   logic [ADDR_W-1:0] addr_q, end_q;
   logic [DATA_W-1:0] sample_reg, shift_reg;
   logic [CNT_W-1:0]  bit_cnt;
   logic              fetch_last;
   logic              shift_done, last_word;

   // Two metastability flops then one history flop per codec clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bclk_sync <= '0;
         lr_sync   <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the chain really is 3 stages.
         bclk_sync <= {bclk_sync[1:0], aud_bclk};
         lr_sync   <= {lr_sync[1:0], aud_daclrck};
      end
   end

   assign bclk_fall  = bclk_sync[2] & ~bclk_sync[1];
   assign lr_fall    = lr_sync[2] & ~lr_sync[1];
   assign lr_rise    = ~lr_sync[2] & lr_sync[1];
   assign shift_done = (bit_cnt == CNT_W'(DATA_W));
   assign last_word  = (addr_q == end_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      if (stop) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (fetch_last) state_nxt = WAIT_L;
            WAIT_L:  if (!pause && lr_fall) state_nxt = SHIFT_L;
            SHIFT_L: if (bclk_fall && shift_done) state_nxt = WAIT_R;
            WAIT_R:  if (lr_rise) state_nxt = SHIFT_R;
            SHIFT_R: if (bclk_fall && shift_done) state_nxt = last_word ? IDLE : FETCH;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      busy           = (state != IDLE);
      sram.sram_ce_n = (state != FETCH);
      sram.sram_oe_n = (state != FETCH);
      sram.sram_ub_n = (state != FETCH);
      sram.sram_lb_n = (state != FETCH);
      sram.sram_we_n = 1'b1;
   end

   assign sram.sram_addr = addr_q;

   // Datapath. Every register here is a plain flop, so all of them are cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         end_q      <= '0;
         sample_reg <= '0;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         fetch_last <= 1'b0;
         aud_dacdat <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            addr_q     <= '0;
            aud_dacdat <= 1'b0;
            fetch_last <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  end_q      <= end_addr;
                  addr_q     <= '0;
                  fetch_last <= 1'b0;
               end
               FETCH: begin
                  fetch_last <= ~fetch_last;
                  if (fetch_last) sample_reg <= sram.sram_dq;
               end
               WAIT_L: if (!pause && lr_fall) begin
                  shift_reg <= sample_reg;
                  bit_cnt   <= '0;
               end
               WAIT_R: if (lr_rise) begin
                  shift_reg <= sample_reg;
                  bit_cnt   <= '0;
               end
               SHIFT_L, SHIFT_R: if (bclk_fall) begin
                  if (!shift_done) begin
                     aud_dacdat <= shift_reg[DATA_W-1];
                     shift_reg  <= {shift_reg[DATA_W-2:0], 1'b0};
                     bit_cnt    <= bit_cnt + 1'b1;
                  end else begin
                     aud_dacdat <= 1'b0;
                     // The last address is never incremented, so a full-range play cannot wrap.
                     if (state == SHIFT_R) begin
                        if (last_word) done   <= 1'b1;
                        else           addr_q <= addr_q + 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_audio_player.sv
// Self-checking bench for audio_player: codec clock generator, I2S DAC capture model
// and a sample-sequence reference built from the SRAM contents.
module tb_audio_player;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 16;
   localparam int FRAME  = 512;

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
   } frame_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              pause = 1'b0;
   logic              stop = 1'b0;
   logic [ADDR_W-1:0] end_addr = '0;
   logic              aud_bclk = 1'b1;
   logic              aud_daclrck = 1'b1;
   logic              aud_dacdat;
   logic              busy;
   logic              done;

   logic [15:0] mem [16];
   logic [15:0] exp_q [$];
   frame_t      frames [$];

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int we_bad = 0;
   int max_addr = 0;
   int stray = 0;

   audio_player_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sram_bus ();

   assign sram_bus.sram_dq = mem[sram_bus.sram_addr];

   audio_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .pause       (pause),
      .stop        (stop),
      .end_addr    (end_addr),
      .sram        (sram_bus.master),
      .aud_bclk    (aud_bclk),
      .aud_daclrck (aud_daclrck),
      .aud_dacdat  (aud_dacdat),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Codec: bclk = clk/8, 32 bclk per half-frame, LR changes on bclk falling edges.
   int div = 0;
   int bitn = 0;
   always @(negedge clk) begin
      if (div == 0) begin
         aud_bclk = 1'b0;
         if (bitn == 0) aud_daclrck = ~aud_daclrck;
         bitn = (bitn == 31) ? 0 : bitn + 1;
      end else if (div == 4) begin
         aud_bclk = 1'b1;
      end
      div = (div == 7) ? 0 : div + 1;
   end

   // I2S receiver: bit 0 after an LR change is the delay slot, bits 1..16 are the word.
   logic        prev_lr = 1'b1;
   int          idx = 0;
   logic [15:0] word = '0;
   logic [15:0] left_word = '0;
   always @(posedge aud_bclk) begin
      if (aud_daclrck != prev_lr) begin
         if (prev_lr) frames.push_back('{left_word, word});
         else         left_word = word;
         idx  = 0;
         word = '0;
      end else begin
         idx++;
      end
      if (idx >= 1 && idx <= 16) word = {word[14:0], aud_dacdat};
      else if (aud_dacdat)       stray++;
      prev_lr = aud_daclrck;
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (sram_bus.sram_we_n !== 1'b1) we_bad++;
      if (busy && int'(sram_bus.sram_addr) > max_addr) max_addr = int'(sram_bus.sram_addr);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [15:0] rnd_word();
      logic [15:0] w;
      do w = 16'($urandom); while (w == 16'h0000);
      return w;
   endfunction

   // Reference: a completed playback is exactly mem[0..e], one sample per frame.
   task automatic expect_play(input int e);
      exp_q.delete();
      for (int i = 0; i <= e; i++) exp_q.push_back(mem[i]);
   endtask

   task automatic check_frames(input string tag);
      frame_t nz [$];
      foreach (frames[i]) if (frames[i].l != 0 || frames[i].r != 0) nz.push_back(frames[i]);
      check($sformatf("%s_count", tag), nz.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < nz.size(); i++) begin
         check($sformatf("%s_L%0d", tag, i), nz[i].l, exp_q[i]);
         check($sformatf("%s_R%0d", tag, i), nz[i].r, exp_q[i]);
      end
   endtask

   task automatic pulse_start(input int e);
      @(posedge clk);
      #1 end_addr = ADDR_W'(e);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int base;
      int n;
      base = done_cnt;
      n = 0;
      while (done_cnt == base && n < budget) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("%s_done_seen", tag), done_cnt > base, 1);
      repeat (600) @(negedge clk);
      check($sformatf("%s_done_once", tag), done_cnt - base, 1);
      check($sformatf("%s_busy_low", tag), busy, 1'b0);
   endtask

   task automatic wait_addr(input string tag, input int a, input int budget);
      int n;
      n = 0;
      while (int'(sram_bus.sram_addr) != a && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, sram_bus.sram_addr, a);
   endtask

   initial begin
      int zeros;
      int i0;
      int base;
      foreach (mem[i]) mem[i] = rnd_word();
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_dacdat", aud_dacdat, 1'b0);
      check("rst_addr", sram_bus.sram_addr, 0);
      check("rst_strobes", {sram_bus.sram_ce_n, sram_bus.sram_oe_n, sram_bus.sram_we_n,
                            sram_bus.sram_ub_n, sram_bus.sram_lb_n}, 5'b11111);

      // Three-word playback
      mem[0] = 16'hA5A5; mem[1] = 16'h8001; mem[2] = 16'h7FFE;
      expect_play(2);
      frames.delete();
      pulse_start(2);
      check("three_busy_rise", busy, 1'b1);
      wait_done("three", 5 * FRAME);
      check_frames("three");

      // Single sample, end_addr = 0
      mem[0] = 16'h1234;
      expect_play(0);
      frames.delete();
      max_addr = 0;
      pulse_start(0);
      wait_done("single", 3 * FRAME);
      check_frames("single");
      check("single_addr_max", max_addr, 0);

      // Pause during SHIFT_L of sample 1, held 5 frames
      for (int i = 0; i < 4; i++) mem[i] = rnd_word();
      expect_play(3);
      @(posedge aud_daclrck);
      frames.delete();
      pulse_start(3);
      @(negedge aud_daclrck);
      repeat (20) @(posedge clk);
      #1 pause = 1'b1;
      repeat (5 * FRAME) @(posedge clk);
      #1 pause = 1'b0;
      wait_done("pause", 8 * FRAME);
      check_frames("pause");
      i0 = -1;
      zeros = 0;
      foreach (frames[i]) begin
         if (frames[i].l != 0 || frames[i].r != 0) begin
            if (i0 >= 0) break;
            i0 = i;
         end else if (i0 >= 0) begin
            zeros++;
         end
      end
      check("pause_silent_frames", zeros, 5);

      // Stop during SHIFT_R of sample 4, then replay
      for (int i = 0; i < 8; i++) mem[i] = rnd_word();
      frames.delete();
      pulse_start(7);
      wait_addr("stop_reach_addr3", 3, 6 * FRAME);
      @(posedge aud_daclrck);
      repeat (40) @(posedge clk);
      base = done_cnt;
      #1 stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      check("stop_busy", busy, 1'b0);
      check("stop_addr", sram_bus.sram_addr, 0);
      check("stop_dacdat", aud_dacdat, 1'b0);
      repeat (600) @(negedge clk);
      check("stop_no_done", done_cnt - base, 0);
      expect_play(2);
      exp_q.push_back(mem[3]);
      begin
         frame_t nz [$];
         foreach (frames[i]) if (frames[i].l != 0 || frames[i].r != 0) nz.push_back(frames[i]);
         check("stop_frame_count", nz.size(), 4);
         for (int i = 0; i < 3 && i < nz.size(); i++) begin
            check($sformatf("stop_L%0d", i), nz[i].l, exp_q[i]);
            check($sformatf("stop_R%0d", i), nz[i].r, exp_q[i]);
         end
         if (nz.size() > 3) check("stop_L3", nz[3].l, exp_q[3]);
      end
      expect_play(2);
      frames.delete();
      pulse_start(2);
      wait_done("replay", 5 * FRAME);
      check_frames("replay");

      // Start together with stop stays idle
      base = done_cnt;
      @(posedge clk);
      #1 start = 1'b1; stop = 1'b1; end_addr = 2;
      @(posedge clk);
      #1 start = 1'b0; stop = 1'b0;
      check("collide_busy_next", busy, 1'b0);
      repeat (50) @(negedge clk);
      check("collide_busy_later", busy, 1'b0);
      check("collide_no_done", done_cnt - base, 0);

      // Second start while busy is ignored; original end_addr honoured
      for (int i = 0; i < 4; i++) mem[i] = rnd_word();
      expect_play(1);
      frames.delete();
      pulse_start(1);
      repeat (100) @(negedge clk);
      check("restart_busy_before", busy, 1'b1);
      pulse_start(3);
      wait_done("restart", 4 * FRAME);
      check_frames("restart");

      // Full address range, no wrap
      foreach (mem[i]) mem[i] = rnd_word();
      expect_play(15);
      frames.delete();
      max_addr = 0;
      pulse_start(15);
      wait_done("full", 18 * FRAME);
      check_frames("full");
      check("full_addr_max", max_addr, 15);

      // Random lengths and start offsets
      for (int k = 0; k < 3; k++) begin
         int e;
         e = int'($urandom_range(0, 4));
         for (int i = 0; i <= e; i++) mem[i] = rnd_word();
         expect_play(e);
         frames.delete();
         repeat ($urandom_range(0, 600)) @(posedge clk);
         pulse_start(e);
         wait_done($sformatf("rnd%0d", k), (e + 3) * FRAME);
         check_frames($sformatf("rnd%0d", k));
      end

      // Async reset mid-FETCH
      base = done_cnt;
      pulse_start(2);
      begin
         int n;
         n = 0;
         while (sram_bus.sram_ce_n !== 1'b0 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
         end
         check("arst_in_fetch", sram_bus.sram_ce_n, 1'b0);
      end
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_addr", sram_bus.sram_addr, 0);
      check("arst_dacdat", aud_dacdat, 1'b0);
      check("arst_strobes", {sram_bus.sram_ce_n, sram_bus.sram_oe_n, sram_bus.sram_we_n,
                             sram_bus.sram_ub_n, sram_bus.sram_lb_n}, 5'b11111);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2 * FRAME) @(negedge clk);
      check("arst_no_resume", busy, 1'b0);
      check("arst_no_done", done_cnt - base, 0);

      check("we_n_always_high", we_bad, 0);
      check("dacdat_zero_outside_word", stray, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
